cla_pipe_adder: RTL
===================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 The module SHALL have parameter GROUP, default 8, meaning bits per carry-lookahead slice and per pipeline stage.
REQ-003 WIDTH SHALL be a positive multiple of GROUP; the stage count is NSTAGE = WIDTH/GROUP.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The ports SHALL be, in order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  module accepts operand set this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- Sub  input  1  1 = compute A - B (two's complement), 0 = A + B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- Sum  output  WIDTH  result
- Cout  output  1  carry-out of the MSB
- Ovf  output  1  signed overflow

Function
REQ-006 The module SHALL accept an operand set when in_valid && in_ready at a rising clk edge; that is a transfer.
REQ-007 The result SHALL be consumed when out_valid && out_ready at a rising clk edge.
REQ-008 Effective operand: Bx = Sub ? ~B : B; effective carry-in: Cx = Sub ? 1 : Cin (Cin ignored when Sub=1).
REQ-009 The result SHALL be {Cout, Sum} = A + Bx + Cx, computed modulo 2^(WIDTH+1).
REQ-010 Ovf SHALL be (A[MSB] == Bx[MSB]) && (Sum[MSB] != A[MSB]).
REQ-011 Stage k (0..NSTAGE-1) SHALL compute GROUP-bit slice k with a carry-lookahead (generate/propagate) network.
REQ-012 Stage k SHALL take its carry-in from the stage k-1 registered carry; stage 0 SHALL take Cx.
REQ-013 Operand slices for stages k>0 SHALL be skew-registered so each slice is computed in cycle k after acceptance.
REQ-014 Completed low slices SHALL be deskew-registered so all Sum bits, Cout and Ovf of one transfer appear together.
REQ-015 Latency SHALL be exactly NSTAGE cycles from the accepting edge to out_valid=1, absent stalls.
REQ-016 Each stage SHALL carry a valid bit; out_valid SHALL be the last-stage valid bit.
REQ-017 Stall condition: stall = out_valid && !out_ready.
REQ-018 in_ready SHALL be !stall (combinational).
REQ-019 While stall=1, every pipeline register, including valid bits, SHALL hold its value.
REQ-020 While stall=0, the pipeline SHALL advance one stage per cycle; bubbles (valid=0) advance like data.
REQ-021 Full throughput: one transfer per cycle SHALL be sustained when out_ready stays 1.
REQ-022 Sum, Cout and Ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Data registers in invalid stages are don't-care, but Sum/Cout/Ovf SHALL read 0 while out_valid=0.
REQ-024 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-025 in_valid=0 on a cycle SHALL insert a bubble; no result is generated for it.

Reset
REQ-026 While rst=1, all valid bits SHALL be 0, out_valid=0, Sum=0, Cout=0, Ovf=0, and in_ready=1, independent of clk.
REQ-027 Asserting rst mid-operation SHALL discard all in-flight transfers; none appears after rst deasserts.
REQ-028 The first transfer SHALL be accepted on the first rising edge with rst=0.

Verification (WIDTH=32, GROUP=8, latency 4)
REQ-029 Setup: A=0x000000FF, B=0x00000001, Cin=0, Sub=0, one transfer, out_ready=1 -> out_valid rises exactly 4 cycles later; Sum=0x00000100, Cout=0, Ovf=0.
REQ-030 Carry ripple across all stages: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Sum=0x00000000, Cout=1, Ovf=0.
REQ-031 Subtract and signed overflow: A=0x80000000, B=0x00000001, Sub=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1; A=0x7FFFFFFF, B=0x00000001, Sub=0 -> Sum=0x80000000, Cout=0, Ovf=1.
REQ-032 Back-to-back streaming with backpressure: 100 random transfers, out_ready toggled randomly -> in_ready == !(out_valid && !out_ready) every cycle; outputs held during stall; results in order; each matches a 33-bit reference model.
REQ-033 Reset mid-flight: 3 transfers accepted, rst pulsed 1 cycle before the first would emerge -> out_valid=0 immediately (asynchronously) and stays 0 until a new transfer completes 4 cycles after acceptance.
REQ-034 Parameter sweep: WIDTH=8, GROUP=8 (latency 1), A=200, B=100, Cin=1 -> Sum=0x2D, Cout=1; WIDTH=16, GROUP=4 (latency 4) random check vs model.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead slice per stage, skewed operands, deskewed sum.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSTAGE = WIDTH / GROUP;

  // Level 0 holds the accepted operands; level k+1 holds slice k done.
  logic [NSTAGE:0] v_q;
  logic [NSTAGE:0] c_q;
  logic [WIDTH-1:0] a_q [NSTAGE+1];
  logic [WIDTH-1:0] b_q [NSTAGE+1];
  logic [WIDTH-1:0] s_q [NSTAGE+1];
  logic [GROUP:0]   sl  [NSTAGE];

  logic             stall;
  logic [WIDTH-1:0] bx;
  logic             cx;

  function automatic logic [GROUP:0] cla_slice(
    input logic [GROUP-1:0] x,
    input logic [GROUP-1:0] y,
    input logic             ci
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Handshake and effective operands
  always_comb begin
    stall    = v_q[NSTAGE] && !out_ready;
    in_ready = !stall;
    bx       = Sub ? ~B : B;
    cx       = Sub ? 1'b1 : Cin;
  end

  // Lookahead slice k works on level k operands and carry
  always_comb begin
    sl = '{default: '0};
    for (int k = 0; k < NSTAGE; k++) begin
      sl[k] = cla_slice(a_q[k][k*GROUP +: GROUP],
                        b_q[k][k*GROUP +: GROUP],
                        c_q[k]);
    end
  end

  // Pipeline advance; everything holds while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k <= NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      c_q[0] <= cx;
      a_q[0] <= A;
      b_q[0] <= bx;
      s_q[0] <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k+1] <= v_q[k];
        c_q[k+1] <= sl[k][GROUP];
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
        s_q[k+1] <= s_q[k];
        s_q[k+1][k*GROUP +: GROUP] <= sl[k][GROUP-1:0];
      end
    end
  end

  // Result outputs read zero when no result is present
  always_comb begin
    out_valid = v_q[NSTAGE];
    Sum       = '0;
    Cout      = 1'b0;
    Ovf       = 1'b0;
    if (v_q[NSTAGE]) begin
      Sum  = s_q[NSTAGE];
      Cout = c_q[NSTAGE];
      Ovf  = (a_q[NSTAGE][WIDTH-1] == b_q[NSTAGE][WIDTH-1]) &&
             (s_q[NSTAGE][WIDTH-1] != a_q[NSTAGE][WIDTH-1]);
    end
  end

endmodule
